// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART FIFO slice.
package uart_pkg;

    localparam int unsigned UART_FIFO_DEPTH = 16;
    localparam int unsigned UART_DATA_W     = 8;

    // Occupancy needs one extra bit so it can represent DEPTH itself.
    function automatic int unsigned fifo_count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// Parametrised FWFT FIFO for the UART TX/RX paths: exact occupancy, thresholds, flush, sticky errors.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W   = UART_DATA_W,
    parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               rd_data,
    input  logic                            flush,
    input  logic                            clr_err,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [fifo_count_w(DEPTH)-1:0]  count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = fifo_count_w(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "uart_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "uart_fifo: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
        $fatal(1, "uart_fifo: AE_LEVEL must be below DEPTH");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              push_ok;
    logic              pop_ok;
    logic              ram_we;

    // Status is decoded from the registered count only.
    assign full         = (cnt_q == CW'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CW'(AF_LEVEL));
    assign almost_empty = (cnt_q <= CW'(AE_LEVEL));
    assign count        = cnt_q;

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign pop_ok  = rd_en && !empty;
    assign push_ok = wr_en && (!full || pop_ok);
    assign ram_we  = reset && !flush && push_ok;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign rd_data = empty ? '0 : ram_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Error set takes priority over clr_err; flush leaves the flags alone.
            overflow  <= (overflow && !clr_err) || (wr_en && !push_ok);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt_q  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push_ok, pop_ok})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo at default parameters (8-bit x 16).
module tb_uart_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       flush;
    logic       clr_err;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    uart_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .flush        (flush),
        .clr_err      (clr_err),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                       input logic fl, input logic ce);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        flush   = fl;
        clr_err = ce;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b0;
        wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        reset = 1'b1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);

        // Basic order: 0x11, 0x22, 0x33.
        cyc(1, 8'h11, 0, 0, 0);
        check("fwft_first", 32'(rd_data), 32'h11);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        check("cnt3", 32'(count), 3);
        for (int i = 0; i < 3; i++) begin
            d = 8'(8'h11 * (i + 1));
            check($sformatf("pop_data%0d", i), 32'(rd_data), 32'(d));
            cyc(0, 8'h00, 1, 0, 0);
            check($sformatf("pop_cnt%0d", i), 32'(count), 32'(2 - i));
        end
        check("drained_empty", 32'(empty), 1);
        check("drained_rd_data", 32'(rd_data), 0);

        // Fill to full, overflow, drain.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            check($sformatf("af_at%0d", i + 1), 32'(almost_full), ((i + 1) >= 14) ? 1 : 0);
        end
        check("full_flag", 32'(full), 1);
        check("full_cnt", 32'(count), 16);
        check("full_ae", 32'(almost_empty), 0);
        cyc(1, 8'hAA, 0, 0, 0);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_cnt", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_drain%0d", i), 32'(rd_data), 32'(i));
            cyc(0, 8'h00, 1, 0, 0);
        end
        check("full_drain_empty", 32'(empty), 1);
        cyc(0, 8'h00, 0, 0, 1);
        check("ovf_clr", 32'(overflow), 0);

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
        cyc(1, 8'h5A, 1, 0, 0);
        check("pp_full_cnt", 32'(count), 16);
        check("pp_full_ovf", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            d = (i == 15) ? 8'h5A : 8'(8'h21 + i);
            check($sformatf("pp_drain%0d", i), 32'(rd_data), 32'(d));
            cyc(0, 8'h00, 1, 0, 0);
        end
        check("pp_drain_empty", 32'(empty), 1);

        // Underflow set/clear; set wins over clr_err.
        cyc(0, 8'h00, 1, 0, 0);
        check("unf_set", 32'(underflow), 1);
        check("unf_cnt", 32'(count), 0);
        cyc(0, 8'h00, 0, 0, 1);
        check("unf_clr", 32'(underflow), 0);
        cyc(0, 8'h00, 1, 0, 1);
        check("unf_set_wins", 32'(underflow), 1);
        cyc(0, 8'h00, 0, 0, 1);
        // Push + pop on empty: push only, underflow set.
        cyc(1, 8'h77, 1, 0, 0);
        check("pp_empty_cnt", 32'(count), 1);
        check("pp_empty_unf", 32'(underflow), 1);
        check("pp_empty_data", 32'(rd_data), 32'h77);
        cyc(0, 8'h00, 1, 0, 1);
        check("pp_empty_pop", 32'(empty), 1);

        // Streaming with pointer wrap against a scoreboard.
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            sb.push_back(d);
            cyc(1, d, 0, 0, 0);
        end
        check("stream_cnt", 32'(count), 5);
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            check($sformatf("stream%0d", i), 32'(rd_data), 32'(sb[0]));
            void'(sb.pop_front());
            sb.push_back(d);
            cyc(1, d, 1, 0, 0);
        end
        check("stream_cnt_end", 32'(count), 5);
        while (sb.size() > 0) begin
            check("stream_tail", 32'(rd_data), 32'(sb[0]));
            void'(sb.pop_front());
            cyc(0, 8'h00, 1, 0, 0);
        end
        check("stream_empty", 32'(empty), 1);

        // Flush discards the queue and a concurrent push; flags survive.
        cyc(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0);
        check("pre_flush_cnt", 32'(count), 6);
        cyc(1, 8'hEE, 0, 1, 0);
        check("flush_cnt", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_unf_kept", 32'(underflow), 1);
        check("flush_rd_data", 32'(rd_data), 0);

        // Mid-traffic reset clears count and sticky flags.
        for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0, 0);
        check("pre_rst_cnt", 32'(count), 9);
        check("pre_rst_ovf", 32'(overflow), 1);
        reset = 1'b0;
        cyc(1, 8'h99, 1, 0, 0);
        reset = 1'b1;
        check("mid_rst_cnt", 32'(count), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_unf", 32'(underflow), 0);
        check("mid_rst_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
